// File: rtl/pixel_arbiter.sv
// Two-requester round-robin arbiter feeding a single VGA pixel write port.
// Grants whole bursts, clips off-screen pixels, and caps each burst at MAX_BURST.
//
//   state    | meaning
//   S_IDLE   | no owner; picks next requester, accepts no pixel
//   S_GRANT0 | requester 0 (stair drawer) owns the write path
//   S_GRANT1 | requester 1 (player drawer) owns the write path
module pixel_arbiter #(
    parameter int MAX_BURST = 200,
    parameter int X_MAX     = 159,
    parameter int Y_MAX     = 119
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [2:0] colour0,
    input  logic       last0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [7:0] x1,
    input  logic [6:0] y1,
    input  logic [2:0] colour1,
    input  logic       last1,
    output logic       gnt1,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       writeEn,
    output logic       busy,
    output logic       overrun,
    output logic       clipped
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);
    localparam logic [7:0] X_LIM   = 8'(X_MAX);
    localparam logic [6:0] Y_LIM   = 7'(Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_prio;
    logic       w_prio_next;
    logic [7:0] r_count;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_colour;
    logic       r_write_en;
    logic       r_overrun;
    logic       r_clipped;

    logic       w_xfer;
    logic       w_sel_last;
    logic [7:0] w_sel_x;
    logic [6:0] w_sel_y;
    logic [2:0] w_sel_colour;
    logic [7:0] w_count_inc;
    logic       w_at_max;
    logic       w_clip;
    logic       w_end;

    // Only the granted requester's inputs are looked at.
    always_comb begin
        w_xfer       = 1'b0;
        w_sel_last   = last0;
        w_sel_x      = x0;
        w_sel_y      = y0;
        w_sel_colour = colour0;
        if (r_state == S_GRANT1) begin
            w_xfer       = req1;
            w_sel_last   = last1;
            w_sel_x      = x1;
            w_sel_y      = y1;
            w_sel_colour = colour1;
        end else if (r_state == S_GRANT0) begin
            w_xfer       = req0;
        end
    end

    assign w_count_inc = r_count + 8'd1;
    assign w_at_max    = (w_count_inc == MAX_CNT);
    assign w_clip      = (w_sel_x > X_LIM) || (w_sel_y > Y_LIM);
    assign w_end       = w_xfer && (w_sel_last || w_at_max);

    always_comb begin
        w_state_next = r_state;
        w_prio_next  = r_prio;
        case (r_state)
            S_IDLE: begin
                if (req0 && req1) begin
                    w_state_next = r_prio ? S_GRANT1 : S_GRANT0;
                end else if (req0) begin
                    w_state_next = S_GRANT0;
                end else if (req1) begin
                    w_state_next = S_GRANT1;
                end
            end
            S_GRANT0: begin
                if (w_end) begin
                    w_state_next = S_IDLE;
                    w_prio_next  = 1'b1;
                end
            end
            S_GRANT1: begin
                if (w_end) begin
                    w_state_next = S_IDLE;
                    w_prio_next  = 1'b0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_prio     <= 1'b0;
            r_count    <= 8'd0;
            r_x        <= 8'd0;
            r_y        <= 7'd0;
            r_colour   <= 3'd0;
            r_write_en <= 1'b0;
            r_overrun  <= 1'b0;
            r_clipped  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_prio     <= w_prio_next;
            // Cleared while idle so every grant starts counting from zero.
            if (r_state == S_IDLE) begin
                r_count <= 8'd0;
            end else if (w_xfer) begin
                r_count <= w_count_inc;
            end
            r_write_en <= w_xfer && !w_clip;
            r_clipped  <= w_xfer && w_clip;
            r_overrun  <= w_xfer && w_at_max && !w_sel_last;
            if (w_xfer && !w_clip) begin
                r_x      <= w_sel_x;
                r_y      <= w_sel_y;
                r_colour <= w_sel_colour;
            end
        end
    end

    assign gnt0    = (r_state == S_GRANT0);
    assign gnt1    = (r_state == S_GRANT1);
    assign busy    = gnt0 | gnt1;
    assign x       = r_x;
    assign y       = r_y;
    assign colour  = r_colour;
    assign writeEn = r_write_en;
    assign overrun = r_overrun;
    assign clipped = r_clipped;

endmodule

// File: tb/tb_pixel_arbiter.sv
// Directed bench for pixel_arbiter: bursts, contention, stalls, overrun, clipping, resets.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pixel_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0, last0, req1, last1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] colour0, colour1;
    logic       gnt0, gnt1, busy, writeEn, overrun, clipped;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    int total = 0;
    int bad   = 0;

    pixel_arbiter dut (
        .clock(clock), .reset(reset),
        .req0(req0), .x0(x0), .y0(y0), .colour0(colour0), .last0(last0), .gnt0(gnt0),
        .req1(req1), .x1(x1), .y1(y1), .colour1(colour1), .last1(last1), .gnt1(gnt1),
        .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy),
        .overrun(overrun), .clipped(clipped)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set0(input logic r, input logic [7:0] px, input logic [6:0] py,
                        input logic [2:0] pc, input logic pl);
        req0 = r; x0 = px; y0 = py; colour0 = pc; last0 = pl;
    endtask

    task automatic set1(input logic r, input logic [7:0] px, input logic [6:0] py,
                        input logic [2:0] pc, input logic pl);
        req1 = r; x1 = px; y1 = py; colour1 = pc; last1 = pl;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        set0(1'b1, 8'd9, 7'd9, 3'd7, 1'b0);
        set1(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        reset = 1'b1;
        tick;
        tick;
        total++;
        if ({gnt0, gnt1, busy, writeEn, overrun, clipped} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000", {gnt0, gnt1, busy, writeEn, overrun, clipped});
        end
        total++;
        if ({x, y, colour} !== 18'd0) begin
            bad++;
            $display("FAIL reset_pixel: got x=%0d y=%0d c=%0d want 0/0/0", x, y, colour);
        end
        reset = 1'b0;
        set0(1'b1, 8'd5, 7'd5, 3'd1, 1'b1);
        tick;
        total++;
        if ({gnt0, gnt1, busy, writeEn} !== 4'b1010) begin
            bad++;
            $display("FAIL reset_first_grant: got %b want 1010", {gnt0, gnt1, busy, writeEn});
        end
        tick;
        total++;
        if ({writeEn, x, y, colour, gnt0} !== {1'b1, 8'd5, 7'd5, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL reset_first_pixel: got we=%b x=%0d y=%0d c=%0d g0=%b want 1/5/5/1/0",
                     writeEn, x, y, colour, gnt0);
        end
        set0(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        tick;
    endtask

    task automatic test_single_burst;
        int writes = 0;
        apply_reset;
        set0(1'b1, 8'd60, 7'd40, 3'b100, 1'b0);
        tick;
        total++;
        if ({gnt0, busy, writeEn} !== 3'b110) begin
            bad++;
            $display("FAIL burst_entry: got %b want 110", {gnt0, busy, writeEn});
        end
        for (int i = 0; i < 200; i++) begin
            set0(1'b1, 8'(60 + i % 40), 7'(40 + i / 40), 3'b100, (i == 199));
            tick;
            if (writeEn === 1'b1) writes++;
            total++;
            if ({writeEn, x, y, colour, overrun, gnt0} !==
                {1'b1, 8'(60 + i % 40), 7'(40 + i / 40), 3'b100, 1'b0, (i != 199)}) begin
                bad++;
                $display("FAIL burst_pixel %0d: got we=%b x=%0d y=%0d c=%0d ov=%b g0=%b", i,
                         writeEn, x, y, colour, overrun, gnt0);
            end
        end
        set0(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        tick;
        total++;
        if ({gnt0, writeEn, overrun} !== 3'b000) begin
            bad++;
            $display("FAIL burst_idle: got %b want 000", {gnt0, writeEn, overrun});
        end
        total++;
        if (writes !== 200) begin
            bad++;
            $display("FAIL burst_count: got %0d writes want 200", writes);
        end
    endtask

    task automatic test_contention;
        apply_reset;
        set0(1'b1, 8'd1, 7'd1, 3'd1, 1'b0);
        set1(1'b1, 8'd100, 7'd100, 3'd6, 1'b0);
        tick;
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL tie_first: got g0g1=%b want 10", {gnt0, gnt1});
        end
        for (int k = 0; k < 3; k++) begin
            set0(1'b1, 8'(k + 1), 7'(k + 1), 3'd1, (k == 2));
            tick;
            total++;
            if ({writeEn, x, y, gnt0, gnt1} !== {1'b1, 8'(k + 1), 7'(k + 1), (k != 2), 1'b0}) begin
                bad++;
                $display("FAIL tie_req0_pixel %0d: got we=%b x=%0d y=%0d g0=%b g1=%b", k,
                         writeEn, x, y, gnt0, gnt1);
            end
        end
        set0(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        tick;
        total++;
        if ({gnt0, gnt1, writeEn} !== 3'b010) begin
            bad++;
            $display("FAIL tie_second: got g0g1we=%b want 010", {gnt0, gnt1, writeEn});
        end
        for (int k = 0; k < 2; k++) begin
            set1(1'b1, 8'(120 + k), 7'(50 + k), 3'd6, (k == 1));
            set0(1'b0, 8'd3, 7'd3, 3'd3, 1'b1);
            tick;
            total++;
            if ({writeEn, x, y, colour, gnt1} !== {1'b1, 8'(120 + k), 7'(50 + k), 3'd6, (k != 1)}) begin
                bad++;
                $display("FAIL tie_req1_pixel %0d: got we=%b x=%0d y=%0d c=%0d g1=%b", k,
                         writeEn, x, y, colour, gnt1);
            end
        end
        set0(1'b1, 8'd7, 7'd7, 3'd2, 1'b1);
        set1(1'b1, 8'd110, 7'd110, 3'd5, 1'b0);
        tick;
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL tie_rr_back: got g0g1=%b want 10", {gnt0, gnt1});
        end
        set1(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        tick;
        total++;
        if ({writeEn, x, y, colour} !== {1'b1, 8'd7, 7'd7, 3'd2}) begin
            bad++;
            $display("FAIL tie_rr_pixel: got we=%b x=%0d y=%0d c=%0d want 1/7/7/2",
                     writeEn, x, y, colour);
        end
        set0(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        tick;
    endtask

    task automatic test_stall;
        set0(1'b1, 8'd10, 7'd20, 3'd0, 1'b0);
        tick;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                set0(1'b0, 8'd50, 7'd50, 3'd7, 1'b0);
                for (int s = 0; s < 3; s++) begin
                    tick;
                    total++;
                    if ({gnt0, writeEn, x, y, colour} !== {1'b1, 1'b0, 8'd14, 7'd24, 3'd4}) begin
                        bad++;
                        $display("FAIL stall_cycle %0d: got g0=%b we=%b x=%0d y=%0d c=%0d", s,
                                 gnt0, writeEn, x, y, colour);
                    end
                end
            end
            set0(1'b1, 8'(10 + i), 7'(20 + i), 3'(i), (i == 9));
            tick;
            total++;
            if ({writeEn, x, y, colour} !== {1'b1, 8'(10 + i), 7'(20 + i), 3'(i)}) begin
                bad++;
                $display("FAIL stall_pixel %0d: got we=%b x=%0d y=%0d c=%0d", i,
                         writeEn, x, y, colour);
            end
        end
        set0(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        tick;
        total++;
        if ({gnt0, writeEn} !== 2'b00) begin
            bad++;
            $display("FAIL stall_end: got g0we=%b want 00", {gnt0, writeEn});
        end
    endtask

    task automatic test_overrun;
        int ovr = 0;
        set1(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        set0(1'b1, 8'd0, 7'd0, 3'd0, 1'b0);
        tick;
        for (int i = 0; i < 200; i++) begin
            set0(1'b1, 8'(i % 100), 7'(i % 100), 3'(i % 8), 1'b0);
            tick;
            if (overrun === 1'b1) ovr++;
            total++;
            if ({writeEn, x, y, colour, overrun, gnt0} !==
                {1'b1, 8'(i % 100), 7'(i % 100), 3'(i % 8), (i == 199), (i != 199)}) begin
                bad++;
                $display("FAIL ovr_pixel %0d: got we=%b x=%0d y=%0d c=%0d ov=%b g0=%b", i,
                         writeEn, x, y, colour, overrun, gnt0);
            end
        end
        total++;
        if (ovr !== 1) begin
            bad++;
            $display("FAIL ovr_pulses: got %0d want 1", ovr);
        end
        set0(1'b1, 8'd0, 7'd0, 3'd0, 1'b0);
        set1(1'b1, 8'd77, 7'd33, 3'd5, 1'b1);
        tick;
        total++;
        if ({gnt0, gnt1, overrun} !== 3'b010) begin
            bad++;
            $display("FAIL ovr_prio_flip: got g0g1ov=%b want 010", {gnt0, gnt1, overrun});
        end
        set0(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        tick;
        total++;
        if ({writeEn, x, y, colour} !== {1'b1, 8'd77, 7'd33, 3'd5}) begin
            bad++;
            $display("FAIL ovr_req1_pixel: got we=%b x=%0d y=%0d c=%0d want 1/77/33/5",
                     writeEn, x, y, colour);
        end
        set1(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        tick;
    endtask

    task automatic test_clip;
        set0(1'b1, 8'd20, 7'd30, 3'd5, 1'b0);
        tick;
        tick;
        total++;
        if ({writeEn, clipped, x, y, colour} !== {1'b1, 1'b0, 8'd20, 7'd30, 3'd5}) begin
            bad++;
            $display("FAIL clip_first: got we=%b cl=%b x=%0d y=%0d c=%0d", writeEn, clipped, x, y, colour);
        end
        set0(1'b1, 8'd160, 7'd10, 3'd3, 1'b0);
        tick;
        total++;
        if ({writeEn, clipped, x, y, colour} !== {1'b0, 1'b1, 8'd20, 7'd30, 3'd5}) begin
            bad++;
            $display("FAIL clip_x160: got we=%b cl=%b x=%0d y=%0d c=%0d", writeEn, clipped, x, y, colour);
        end
        set0(1'b1, 8'd10, 7'd120, 3'd6, 1'b0);
        tick;
        total++;
        if ({writeEn, clipped, x, y, colour} !== {1'b0, 1'b1, 8'd20, 7'd30, 3'd5}) begin
            bad++;
            $display("FAIL clip_y120: got we=%b cl=%b x=%0d y=%0d c=%0d", writeEn, clipped, x, y, colour);
        end
        set0(1'b1, 8'd159, 7'd119, 3'd2, 1'b1);
        tick;
        total++;
        if ({writeEn, clipped, x, y, colour, gnt0} !== {1'b1, 1'b0, 8'd159, 7'd119, 3'd2, 1'b0}) begin
            bad++;
            $display("FAIL clip_corner: got we=%b cl=%b x=%0d y=%0d c=%0d g0=%b",
                     writeEn, clipped, x, y, colour, gnt0);
        end
        set0(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        tick;
        total++;
        if ({writeEn, clipped} !== 2'b00) begin
            bad++;
            $display("FAIL clip_after: got we/cl=%b want 00", {writeEn, clipped});
        end
    endtask

    task automatic test_reset_mid;
        set0(1'b1, 8'd0, 7'd0, 3'd0, 1'b0);
        tick;
        for (int i = 0; i < 56; i++) begin
            set0(1'b1, 8'(i), 7'(i), 3'(i % 8), 1'b0);
            tick;
        end
        total++;
        if ({writeEn, x, y, colour, gnt0} !== {1'b1, 8'd55, 7'd55, 3'd7, 1'b1}) begin
            bad++;
            $display("FAIL mid_pre: got we=%b x=%0d y=%0d c=%0d g0=%b", writeEn, x, y, colour, gnt0);
        end
        set0(1'b1, 8'd56, 7'd56, 3'd0, 1'b0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        total++;
        if ({gnt0, gnt1, busy, writeEn, x, y, colour, overrun, clipped} !== 24'd0) begin
            bad++;
            $display("FAIL mid_reset: got g0=%b g1=%b bz=%b we=%b x=%0d y=%0d c=%0d ov=%b cl=%b",
                     gnt0, gnt1, busy, writeEn, x, y, colour, overrun, clipped);
        end
        tick;
        total++;
        if ({gnt0, writeEn} !== 2'b10) begin
            bad++;
            $display("FAIL mid_regrant: got g0we=%b want 10", {gnt0, writeEn});
        end
        for (int i = 0; i < 200; i++) begin
            set0(1'b1, 8'(i % 100), 7'(i % 50), 3'(i % 8), 1'b0);
            tick;
            total++;
            if ({writeEn, x, y, overrun, gnt0} !==
                {1'b1, 8'(i % 100), 7'(i % 50), (i == 199), (i != 199)}) begin
                bad++;
                $display("FAIL mid_fresh %0d: got we=%b x=%0d y=%0d ov=%b g0=%b", i,
                         writeEn, x, y, overrun, gnt0);
            end
        end
        set0(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        tick;
    endtask

    initial begin
        reset = 1'b0;
        set0(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        set1(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        test_reset;
        test_single_burst;
        test_contention;
        test_stall;
        test_overrun;
        test_clip;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_arbiter.md
PIXEL_ARBITER -- requirements
Module: pixel_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 200, is the maximum number of pixels accepted per grant.
REQ-002 Parameter: X_MAX, default 159, is the largest visible x coordinate.
REQ-003 Parameter: Y_MAX, default 119, is the largest visible y coordinate.
REQ-004 Port: clock, input, 1 bit; the single clock; all logic is on the rising edge.
REQ-005 Port: reset, input, 1 bit; synchronous, active-high reset.
REQ-006 Port: req0, input, 1 bit; requester 0 (the stair drawer) has a valid pixel.
REQ-007 Port: x0 [7:0], y0 [6:0] and colour0 [2:0], inputs; requester 0 pixel.
REQ-008 Port: last0, input, 1 bit; the requester 0 pixel is the final pixel of its shape.
REQ-009 Port: gnt0, output, 1 bit; requester 0 owns the write path.
REQ-010 Port: req1, x1 [7:0], y1 [6:0], colour1 [2:0], last1, inputs, and gnt1, output; the same roles for requester 1 (the player drawer).
REQ-011 Port: x [7:0], y [6:0] and colour [2:0], outputs; the pixel sent to the VGA adapter.
REQ-012 Port: writeEn, output, 1 bit; the VGA adapter write strobe.
REQ-013 Port: busy, output, 1 bit; high whenever either grant is held.
REQ-014 Port: overrun, output, 1 bit; one-cycle pulse when a burst is cut at MAX_BURST.
REQ-015 Port: clipped, output, 1 bit; one-cycle pulse when an off-screen pixel is discarded.

Function
REQ-016 The block SHALL implement the states IDLE, GRANT0 and GRANT1.
REQ-017 The block SHALL drive gnt0 = (state==GRANT0), gnt1 = (state==GRANT1) and busy = gnt0|gnt1, directly from the state register.
REQ-018 IDLE transitions: only req0 -> GRANT0; only req1 -> GRANT1; neither -> stay in IDLE.
REQ-019 IDLE, both req0 and req1 high: go to GRANT(prio); prio is a 1-bit round-robin pointer.
REQ-020 The block SHALL accept no pixel in IDLE, so the first transfer happens no earlier than the cycle after req rises.
REQ-021 A transfer SHALL occur on each clock edge where gntN && reqN.
REQ-022 A cycle with gntN high and reqN low SHALL be a stall: grant held, burst count unchanged, writeEn=0 on the next cycle.
REQ-023 On a transfer, x, y and colour SHALL register xN, yN and colourN, and writeEn SHALL be 1 on the following cycle; latency is exactly 1 cycle.
REQ-024 When no transfer occurs, writeEn SHALL be 0 on the following cycle, and x, y and colour SHALL hold their last values.
REQ-025 Clipping: a transferred pixel with xN>X_MAX or yN>Y_MAX SHALL be consumed, with writeEn=0, x/y/colour unchanged, and clipped=1 for one cycle.
REQ-026 An 8-bit burst counter SHALL reset to 0 on entry to a GRANT state and increment once per transfer.
REQ-027 A burst SHALL end on the transfer that has lastN=1, or on the transfer that brings the count to MAX_BURST.
REQ-028 At the end of a burst, the state SHALL return to IDLE on the next edge, and prio SHALL be set to the other requester.
REQ-029 When both end conditions coincide, the burst SHALL end normally, with overrun=0.
REQ-030 When the count reaches MAX_BURST without lastN, overrun SHALL pulse 1 for one cycle, aligned with that pixel's writeEn.
REQ-031 Every burst SHALL be followed by at least one IDLE cycle, so consecutive grants are never back-to-back.
REQ-032 The inputs of the non-granted requester SHALL be ignored entirely.
REQ-033 No combinational path SHALL exist from any req, x, y or colour input to any output.

Reset
REQ-034 When reset=1 at an edge, the block SHALL set state=IDLE and prio=0 (requester 0 first).
REQ-035 When reset=1 at an edge, the block SHALL set burst count=0.
REQ-036 When reset=1 at an edge, the block SHALL set x=0, y=0, colour=0, writeEn=0, overrun=0 and clipped=0.
REQ-037 Reset asserted mid-burst SHALL abort the burst, and the pixel presented in that cycle SHALL NOT be written.
REQ-038 After reset is released, gnt0 and gnt1 SHALL be low for at least one cycle.

Verification
REQ-039 Single burst: req0 held; 200 pixels, x0=60..99 over y0=40..44, colour0=3'b100, last0 on the 200th -> 200 writeEn pulses, each one cycle after its gnt0 transfer; then IDLE; overrun=0.
REQ-040 Contention: req0 and req1 both rise in the same cycle after reset -> GRANT0 first; after last0, one IDLE cycle, then GRANT1; the next tie grants requester 0.
REQ-041 Stall: req0 drops for 3 cycles mid-burst -> writeEn=0 for exactly those 3 cycles; gnt0 stays high; no pixel is lost or duplicated.
REQ-042 Overrun: a requester streams 250 pixels with last0 never set -> burst ends after pixel 200; overrun pulses once; prio flips.
REQ-043 Clip: pixels (160,10) and (10,120) are transferred -> clipped pulses twice; writeEn=0 for both; x/y keep their prior values.
REQ-044 Reset mid-burst: reset=1 for 1 cycle at pixel 57 -> next cycle writeEn=0, x=y=colour=0, gnt0=0; a fresh burst then starts with its count at 0.
